// File: rtl/osc_disp_pkg.sv
// Shared constants, state encoding and decimal-point decode for the
// oscilloscope display path.
package osc_disp_pkg;

    localparam int DIGITS = 6;
    localparam int BCD_W  = 24;
    localparam int BIN_W  = 20;

    localparam logic [BIN_W-1:0] MAX_DEC = 20'd999999;
    localparam logic [2:0]       DP_NONE = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_e;

    // One-hot decimal point for digit index 0..5; indices 6 and 7 light nothing.
    function automatic logic [DIGITS-1:0] dp_decode(input logic [2:0] sel);
        dp_decode = '0;
        if (sel != DP_NONE && sel != 3'd6)
            dp_decode = 6'b000001 << sel;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: digits of 5 or more get +3 before the shift,
// so the shifted digit lands in 0..9 with a clean carry into the next digit.
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 20-bit binary to 6-digit packed BCD converter, one bit per clock.
// Outputs only change on the LOAD cycle so the display never sees partial results.
// Build option: define BCD_SATURATE_EN to clamp out-of-range inputs to 999999
// instead of showing the value modulo 1000000.
module bin2bcd_seq
    import osc_disp_pkg::*;
#(
    parameter int IN_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IN_W-1:0]   bin,
    input  logic [2:0]        dp_sel,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  num,
    output logic [DIGITS-1:0] pts,
    output logic              ovf
);

    state_e              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [IN_W-1:0]     sr_q, sr_d;
    logic [BCD_W-1:0]    acc_q, acc_d;
    logic [BCD_W-1:0]    acc_adj;
    logic [2:0]          dp_q, dp_d;
    logic                ovfc_q, ovfc_d;
    logic [BCD_W-1:0]    num_q, num_d;
    logic [DIGITS-1:0]   pts_q, pts_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [BCD_W-1:0]    result;

    // Per-digit add-3 correction of the accumulator ahead of each shift.
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        bcd_add3 u_add3 (
            .d_i (acc_q[4*k +: 4]),
            .d_o (acc_adj[4*k +: 4])
        );
    end

`ifdef BCD_SATURATE_EN
    assign result = ovfc_q ? 24'h999999 : acc_q;
`else
    assign result = acc_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: 20 shift cycles, then one commit cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == 5'd0) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values per state.
    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        acc_d  = acc_q;
        dp_d   = dp_q;
        ovfc_d = ovfc_q;
        num_d  = num_q;
        pts_d  = pts_q;
        ovf_d  = ovf_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d   = bin;
                    acc_d  = '0;
                    cnt_d  = 5'(IN_W - 1);
                    dp_d   = dp_sel;
                    ovfc_d = (bin > MAX_DEC);
                    busy_d = 1'b1;
                end
            end
            SHIFT: begin
                // Top digit's outgoing bit falls off the end.
                acc_d = {acc_adj[BCD_W-2:0], sr_q[IN_W-1]};
                sr_d  = {sr_q[IN_W-2:0], 1'b0};
                cnt_d = cnt_q - 5'd1;
            end
            LOAD: begin
                num_d  = result;
                pts_d  = dp_decode(dp_q);
                ovf_d  = ovfc_q;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sr_q   <= '0;
            acc_q  <= '0;
            dp_q   <= '0;
            ovfc_q <= 1'b0;
            num_q  <= '0;
            pts_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            acc_q  <= acc_d;
            dp_q   <= dp_d;
            ovfc_q <= ovfc_d;
            num_q  <= num_d;
            pts_q  <= pts_d;
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign num  = num_q;
    assign pts  = pts_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases plus random
// values against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] bin = '0;
    logic [2:0]  dp_sel = '0;
    logic        busy, done, ovf;
    logic [23:0] num;
    logic [5:0]  pts;

    int total = 0;
    int bad   = 0;

    logic [23:0] cur_num = '0;
    logic [5:0]  cur_pts = '0;
    logic        cur_ovf = 1'b0;

    bin2bcd_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bin    (bin),
        .dp_sel (dp_sel),
        .busy   (busy),
        .done   (done),
        .num    (num),
        .pts    (pts),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decimal digits of the value (mod 1e6, or clamped when saturating).
    function automatic logic [23:0] model_num(input int unsigned v);
        int unsigned m;
        logic [23:0] r;
        r = '0;
`ifdef BCD_SATURATE_EN
        m = (v > 999999) ? 999999 : v;
`else
        m = v % 1000000;
`endif
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] model_pts(input int unsigned dp);
        return (dp < 6) ? 6'(1 << dp) : 6'd0;
    endfunction

    // One conversion. ign_at: cycle index whose edge samples a stray start
    // (bin=42); rst_at: cycle index after which reset is pulsed (aborts).
    task automatic conv(input logic [19:0] b, input logic [2:0] dp,
                        input int ign_at, input int rst_at);
        logic [23:0] en;
        logic [5:0]  ep;
        logic        eo;
        en = model_num(b);
        ep = model_pts(dp);
        eo = (b > 20'd999999);
        start = 1'b1; bin = b; dp_sel = dp;
        @(posedge clk); #1;
        start = 1'b0; bin = 20'($urandom); dp_sel = 3'($urandom);
        chk("busy_e0", busy, 1);
        chk("done_e0", done, 0);
        if (ign_at == 1) begin start = 1'b1; bin = 20'd42; end
        for (int i = 1; i <= 21; i++) begin
            @(posedge clk); #1;
            if (i == rst_at) begin
                rst_n = 1'b0; #1;
                chk("rst_num", num, 0);
                chk("rst_pts", pts, 0);
                chk("rst_ovf", ovf, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                #2 rst_n = 1'b1;
                cur_num = '0; cur_pts = '0; cur_ovf = 1'b0;
                return;
            end
            if (i == ign_at - 1) begin start = 1'b1; bin = 20'd42; end
            else start = 1'b0;
            if (i < 21) begin
                chk("busy_mid", busy, 1);
                chk("done_mid", done, 0);
                chk("num_hold", num, cur_num);
            end else begin
                chk("done_lat", done, 1);
                chk("busy_end", busy, 0);
                chk("num", num, en);
                chk("pts", pts, ep);
                chk("ovf", ovf, eo);
            end
        end
        cur_num = en; cur_pts = ep; cur_ovf = eo;
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #12;
        chk("rst0_num", num, 0);
        chk("rst0_pts", pts, 0);
        chk("rst0_ovf", ovf, 0);
        chk("rst0_busy", busy, 0);
        chk("rst0_done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        conv(20'd0,       3'd7, 0, 0);
        conv(20'd123456,  3'd2, 0, 0);
        conv(20'd999999,  3'd5, 0, 0);
        conv(20'd1000000, 3'd0, 0, 0);
        conv(20'd1048575, 3'd6, 0, 0);

        // Stray start sampled at E10 must not queue or retrigger.
        conv(20'd777777, 3'd3, 10, 0);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            chk("no_second_done", done, 0);
            chk("no_second_busy", busy, 0);
        end

        // Start held into the LOAD edge only is ignored.
        conv(20'd654321, 3'd1, 21, 0);
        chk("load_start_num", num, 24'h654321);

        // Reset in the middle of a conversion, then a clean one.
        conv(20'd888888, 3'd4, 0, 12);
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_num", num, 0);
        conv(20'd314159, 3'd0, 0, 0);

        for (int n = 0; n < 25; n++) begin
            logic [19:0] r;
            r = (n % 5 == 0) ? 20'($urandom_range(999990, 1048575))
                             : 20'($urandom_range(0, 1048575));
            conv(r, 3'($urandom_range(0, 7)), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
